// File: rtl/facto_pkg.sv
// facto_pkg: shared constants and types for the FactoCore job scheduler.
//   - FactoCore slave register map
//   - scheduler FSM state encoding (4-bit)
//   - bus request payload and the per-state bus decode helper
package facto_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned RESULT_W = 128;

  localparam logic [ADDR_W-1:0] ADDR_OPSTART  = 16'h7000;
  localparam logic [ADDR_W-1:0] ADDR_OPCLEAR  = 16'h7008;
  localparam logic [ADDR_W-1:0] ADDR_OPDONE   = 16'h7010;
  localparam logic [ADDR_W-1:0] ADDR_INTREN   = 16'h7018;
  localparam logic [ADDR_W-1:0] ADDR_OPERAND  = 16'h7020;
  localparam logic [ADDR_W-1:0] ADDR_RESULT_H = 16'h7028;
  localparam logic [ADDR_W-1:0] ADDR_RESULT_L = 16'h7030;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_OPND  = 4'd1,
    WR_INTEN = 4'd2,
    WR_START = 4'd3,
    WAIT_INT = 4'd4,
    RD_HI    = 4'd5,
    RD_LO    = 4'd6,
    CAP_LO   = 4'd7,
    WR_CLEAR = 4'd8,
    RESP     = 4'd9
  } state_t;

  typedef struct packed {
    logic              sel;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } bus_req_t;

  // Bus transaction driven while the FSM sits in state s; idle bus elsewhere.
  function automatic bus_req_t bus_for_state(input state_t s, input logic [DATA_W-1:0] operand);
    bus_req_t b;
    b = '0;
    case (s)
      WR_OPND: begin
        b.sel  = 1'b1;
        b.wr   = 1'b1;
        b.addr = ADDR_OPERAND;
        b.din  = operand;
      end
      WR_INTEN: begin
        b.sel  = 1'b1;
        b.wr   = 1'b1;
        b.addr = ADDR_INTREN;
        b.din  = DATA_W'(1);
      end
      WR_START: begin
        b.sel  = 1'b1;
        b.wr   = 1'b1;
        b.addr = ADDR_OPSTART;
        b.din  = DATA_W'(1);
      end
      RD_HI: begin
        b.sel  = 1'b1;
        b.addr = ADDR_RESULT_H;
      end
      RD_LO: begin
        b.sel  = 1'b1;
        b.addr = ADDR_RESULT_L;
      end
      WR_CLEAR: begin
        b.sel  = 1'b1;
        b.wr   = 1'b1;
        b.addr = ADDR_OPCLEAR;
        b.din  = DATA_W'(1);
      end
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   : request vector
//   ptr   : highest-priority requester index (owned by the caller)
//   grant : one-hot grant of the first requester at or after ptr, wrapping
//   idx   : binary index of the granted requester
//   any   : at least one request is set
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic        found;
  int unsigned pos;

  // Scan N_REQ positions starting at ptr; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(ptr) + k) % N_REQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/facto_job_sched.sv
// facto_job_sched: round-robin job scheduler and bus master for one FactoCore.
//   clk, reset_n     : clock, synchronous active-low reset
//   req_valid/ready  : per-requester job handshake (ready is a one-cycle one-hot grant)
//   req_operand      : flattened 64-bit operands, requester i at [64i+63:64i]
//   resp_valid/ready : per-requester response handshake (valid is one-hot)
//   resp_result/err  : 128-bit factorial {hi,lo}; err marks range reject or timeout
//   m_sel/wr/addr/din/dout : master port onto the core slave bus
//   interrupt        : core completion interrupt (level)
module facto_job_sched
  import facto_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned MAX_OPERAND    = 34,
  parameter int unsigned TIMEOUT_CYCLES = 16384
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [64*N_REQ-1:0]   req_operand,
  output logic [N_REQ-1:0]      resp_valid,
  input  logic [N_REQ-1:0]      resp_ready,
  output logic [RESULT_W-1:0]   resp_result,
  output logic                  resp_err,
  output logic                  m_sel,
  output logic                  m_wr,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_din,
  input  logic [DATA_W-1:0]     m_dout,
  input  logic                  interrupt
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t            state, next_state;
  logic [IDX_W-1:0]  rr_ptr, g_idx, arb_idx;
  logic [N_REQ-1:0]  arb_grant;
  logic              arb_any;
  logic [DATA_W-1:0] operand, hi, lo;
  logic              err;
  logic [CNT_W-1:0]  cnt;
  bus_req_t          bus_q, bus_nxt;
  logic [DATA_W-1:0] opnd_arr [N_REQ];
  logic              grant_take, opnd_bad, timeout_hit, reject, resp_enter, resp_exit;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Unflatten operand bus so the granted one can be selected by index.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      opnd_arr[i] = req_operand[i*64 +: 64];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and per-cycle control decode.
  // IDLE has two phases: arbitrate (req_ready low), then range-check the
  // latched operand while req_ready is being pulsed.
  always_comb begin
    next_state  = state;
    grant_take  = 1'b0;
    timeout_hit = 1'b0;
    opnd_bad    = operand > DATA_W'(MAX_OPERAND);
    case (state)
      IDLE: begin
        if (|req_ready)   next_state = opnd_bad ? RESP : WR_OPND;
        else if (arb_any) grant_take = 1'b1;
      end
      WR_OPND:  next_state = WR_INTEN;
      WR_INTEN: next_state = WR_START;
      WR_START: next_state = WAIT_INT;
      WAIT_INT: begin
        if (interrupt) begin
          next_state = RD_HI;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          next_state  = WR_CLEAR;
        end
      end
      RD_HI:    next_state = RD_LO;
      RD_LO:    next_state = CAP_LO;
      CAP_LO:   next_state = WR_CLEAR;
      WR_CLEAR: next_state = RESP;
      RESP:     if (resp_ready[g_idx]) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    reject     = (state == IDLE) && (|req_ready) && opnd_bad;
    resp_enter = (next_state == RESP) && (state != RESP);
    resp_exit  = (state == RESP) && (next_state != RESP);
    bus_nxt    = bus_for_state(next_state, operand);
  end

  // Job datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      g_idx       <= '0;
      operand     <= '0;
      hi          <= '0;
      lo          <= '0;
      err         <= 1'b0;
      cnt         <= '0;
      bus_q       <= '0;
      req_ready   <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      req_ready <= grant_take ? arb_grant : '0;
      bus_q     <= bus_nxt;
      cnt       <= (state == WAIT_INT) ? cnt + CNT_W'(1) : '0;

      if (grant_take) begin
        g_idx   <= arb_idx;
        operand <= opnd_arr[arb_idx];
        rr_ptr  <= (32'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + IDX_W'(1);
        err     <= 1'b0;
      end else if (reject || timeout_hit) begin
        err <= 1'b1;
      end

      // m_dout is valid the cycle after each read is issued.
      if (state == RD_LO)  hi <= m_dout;
      if (state == CAP_LO) lo <= m_dout;

      if (resp_enter) begin
        resp_valid  <= N_REQ'(1) << g_idx;
        resp_err    <= reject | err;
        resp_result <= (reject | err) ? '0 : {hi, lo};
      end else if (resp_exit) begin
        resp_valid  <= '0;
        resp_err    <= 1'b0;
        resp_result <= '0;
      end
    end
  end

  assign m_sel  = bus_q.sel;
  assign m_wr   = bus_q.wr;
  assign m_addr = bus_q.addr;
  assign m_din  = bus_q.din;

endmodule

// File: tb/tb_facto_job_sched.sv
// tb_facto_job_sched: directed + randomized bench for facto_job_sched with a
// behavioural FactoCore slave and a request/response reference model.
module tb_facto_job_sched;
  import facto_pkg::*;

  localparam int unsigned NR  = 2;
  localparam int unsigned TMO = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [64*NR-1:0]  req_operand;
  logic [127:0]      resp_result;
  logic              resp_err, m_sel, m_wr;
  logic [15:0]       m_addr;
  logic [63:0]       m_din, m_dout;
  logic              interrupt;

  facto_job_sched #(.N_REQ(NR), .MAX_OPERAND(34), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err),
    .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din),
    .m_dout(m_dout), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nerr = 0;

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] p;
    p = 128'd1;
    for (int i = 2; i <= int'(n); i++) p = p * 128'(i);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural FactoCore slave.
  logic [63:0]  c_opnd;
  logic         c_ien, c_busy;
  int           c_cnt;
  logic [127:0] c_res;
  int           lat_cfg = 5;
  bit           irq_dis = 1'b0;
  int           irq_cyc;

  always @(posedge clk) begin
    if (!reset_n) begin
      c_opnd <= '0; c_ien <= 1'b0; c_busy <= 1'b0; c_cnt <= 0;
      c_res <= '0; interrupt <= 1'b0; m_dout <= '0; irq_cyc <= -1;
    end else begin
      if (m_sel && !m_wr) begin
        if (m_addr == ADDR_RESULT_H)      m_dout <= c_res[127:64];
        else if (m_addr == ADDR_RESULT_L) m_dout <= c_res[63:0];
        else                              m_dout <= '0;
      end
      if (c_busy) begin
        if (c_cnt == 0) begin
          c_busy <= 1'b0;
          if (c_ien && !irq_dis) begin
            interrupt <= 1'b1;
            irq_cyc   <= cyc + 1;
          end
        end else begin
          c_cnt <= c_cnt - 1;
        end
      end
      if (m_sel && m_wr) begin
        case (m_addr)
          ADDR_OPERAND: c_opnd <= m_din;
          ADDR_INTREN:  c_ien  <= m_din[0];
          ADDR_OPSTART: if (m_din[0]) begin
            c_busy <= 1'b1; c_cnt <= lat_cfg; c_res <= fact(c_opnd); irq_cyc <= -1;
          end
          ADDR_OPCLEAR: if (m_din[0]) begin
            interrupt <= 1'b0; c_busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Bus activity log: {cycle, wr, addr, din}.
  logic [112:0] blog[$];
  always @(negedge clk) if (m_sel === 1'b1) blog.push_back({32'(cyc), m_wr, m_addr, m_din});

  // Reference model of pending requests and the round-robin pointer.
  bit           pend [NR];
  logic [63:0]  pop  [NR];
  int           ptr = 0;
  int           last_grant;
  logic [127:0] last_result;

  function automatic int pick();
    for (int k = 0; k < int'(NR); k++) begin
      int j;
      j = (ptr + k) % NR;
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  task automatic raise(input int r, input logic [63:0] op);
    pend[r] = 1'b1;
    pop[r]  = op;
    req_operand[r*64 +: 64] = op;
    req_valid[r] = 1'b1;
  endtask

  task automatic get_grant(input int eg, output int t, output bit ok);
    int rc;
    rc = 0;
    do begin @(negedge clk); rc++; end while (req_ready === '0 && rc < 100);
    ok = (req_ready !== '0);
    t  = cyc;
    if (!ok) begin
      ncmp++; nerr++;
      $error("FAIL grant_wait: observed no grant, expected requester %0d", eg);
      return;
    end
    chk("grant", 128'(req_ready), 128'(NR'(1) << eg));
    for (int k = 0; k < int'(NR); k++) if (req_ready[k]) last_grant = k;
    req_valid[eg] = 1'b0;
    pend[eg] = 1'b0;
    ptr = (eg + 1) % NR;
  endtask

  // Serve the job the model expects next and check timing, bus trace and result.
  task automatic serve(input int hold);
    int eg, t, rv, erv, rc, b0, w;
    bit ok, bad, tmo, eerr;
    logic [63:0]  op;
    logic [127:0] eres;
    logic [NR-1:0] ev_valid;
    logic [112:0] ev[$];
    eg = pick();
    if (eg < 0) return;
    b0 = blog.size();
    get_grant(eg, t, ok);
    if (!ok) return;
    op   = pop[eg];
    bad  = op > 64'd34;
    tmo  = !bad && irq_dis;
    eerr = bad || tmo;
    eres = eerr ? 128'd0 : fact(op);
    ev_valid = NR'(1) << eg;
    rc = 0;
    while (resp_valid === '0 && rc < 200) begin @(negedge clk); rc++; end
    if (resp_valid === '0) begin
      ncmp++; nerr++;
      $error("FAIL resp_wait: observed no resp_valid, expected requester %0d", eg);
      return;
    end
    rv = cyc;
    chk("resp_valid", 128'(resp_valid), 128'(ev_valid));
    chk("resp_err", 128'(resp_err), 128'(eerr));
    chk("resp_result", resp_result, eres);
    last_result = resp_result;
    if (bad) begin
      erv = t + 1;
    end else begin
      ev.push_back({32'(t + 1), 1'b1, ADDR_OPERAND, op});
      ev.push_back({32'(t + 2), 1'b1, ADDR_INTREN, 64'd1});
      ev.push_back({32'(t + 3), 1'b1, ADDR_OPSTART, 64'd1});
      if (tmo) begin
        ev.push_back({32'(t + 4 + TMO), 1'b1, ADDR_OPCLEAR, 64'd1});
        erv = t + 5 + TMO;
      end else begin
        w = irq_cyc;
        ev.push_back({32'(w + 1), 1'b0, ADDR_RESULT_H, 64'd0});
        ev.push_back({32'(w + 2), 1'b0, ADDR_RESULT_L, 64'd0});
        ev.push_back({32'(w + 4), 1'b1, ADDR_OPCLEAR, 64'd1});
        erv = w + 5;
      end
    end
    chk("resp_cycle", 128'(rv), 128'(erv));
    chk("bus_count", 128'(blog.size() - b0), 128'(ev.size()));
    for (int i = 0; i < ev.size() && b0 + i < blog.size(); i++) chk("bus_event", 128'(blog[b0 + i]), 128'(ev[i]));
    // Hold off acceptance while the other requester's resp_ready is asserted.
    for (int i = 0; i < hold; i++) begin
      resp_ready = ~ev_valid;
      @(negedge clk);
      chk("hold_valid", 128'(resp_valid), 128'(ev_valid));
      chk("hold_result", {resp_result[126:0], resp_err}, {eres[126:0], eerr});
    end
    resp_ready = ev_valid;
    @(negedge clk);
    resp_ready = '0;
    chk("resp_drop", 128'(resp_valid), 128'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && pick() >= 0; i++) serve(0);
  endtask

  initial begin
    int t;
    bit ok;
    reset_n = 1'b0; req_valid = '0; resp_ready = '0; req_operand = '0;
    repeat (3) @(negedge clk);
    chk("reset_hs", {122'd0, req_ready, resp_valid, resp_err, m_sel, m_wr}, 128'd0);
    chk("reset_data", {resp_result[63:0], m_din}, 128'd0);
    chk("reset_bus", {resp_result[127:64], 48'd0, m_addr}, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Operand 7 from requester 0.
    raise(0, 64'd7); serve(0);
    chk("op7_value", last_result, 128'h13B0);
    // Boundary operands.
    raise(0, 64'd34); serve(2);
    chk("op34_hi_nz", 128'(last_result[127:64] != 64'd0), 128'd1);
    raise(1, 64'd0); serve(0);
    chk("op0_value", last_result, 128'd1);

    // Both requesters valid continuously.
    for (int i = 0; i < 4; i++) begin
      if (!pend[0]) raise(0, 64'd3);
      if (!pend[1]) raise(1, 64'd4);
      serve(0);
      chk("rr_order", 128'(last_grant), 128'(i % 2));
    end
    drain();

    // Out-of-range operand is rejected without touching the core.
    raise(1, 64'd35); serve(0);

    // Response held for 10 cycles.
    raise(0, 64'd12); serve(10);

    // Reset while waiting for the interrupt.
    lat_cfg = 40;
    raise(0, 64'd20);
    get_grant(0, t, ok);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_hs", {122'd0, req_ready, resp_valid, resp_err, m_sel, m_wr}, 128'd0);
    chk("midrst_data", {resp_result[63:0], m_din}, 128'd0);
    chk("midrst_bus", {resp_result[127:64], 48'd0, m_addr}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ptr = 0;
    lat_cfg = 3;
    raise(1, 64'd5); raise(0, 64'd6);
    serve(0);
    chk("rst_ptr", 128'(last_grant), 128'd0);
    serve(0);

    // Interrupt never arrives: timeout, then a normal job.
    irq_dis = 1'b1;
    raise(0, 64'd9); serve(0);
    irq_dis = 1'b0;
    raise(1, 64'd10); serve(1);

    // Randomized traffic.
    for (int it = 0; it < 14; it++) begin
      for (int r = 0; r < int'(NR); r++)
        if (!pend[r] && $urandom_range(0, 1) == 1) raise(r, 64'($urandom_range(0, 40)));
      if (pick() < 0) raise(int'($urandom_range(0, NR - 1)), 64'($urandom_range(0, 40)));
      lat_cfg = int'($urandom_range(0, 30));
      serve(int'($urandom_range(0, 3)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
